// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule definitions: widths, round-key count, Rcon lookup,
// GF(2^8) multiply used by the S-box, and the controller state encoding.
package aes_pkg;

  localparam int AES_256_KEY_LENGTH    = 256;
  localparam int AES_BLOCK_SIZE        = 128;
  localparam int AES256_NUM_ROUND_KEYS = 15;

  typedef logic [3:0] roundIdx_t;

  typedef enum logic {IDLE, EMIT} state_e;

  function automatic logic [31:0] rcon(input logic [2:0] idx);
    logic [7:0] rc;
    case (idx)
      3'd1:    rc = 8'h01;
      3'd2:    rc = 8'h02;
      3'd3:    rc = 8'h04;
      3'd4:    rc = 8'h08;
      3'd5:    rc = 8'h10;
      3'd6:    rc = 8'h20;
      3'd7:    rc = 8'h40;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  // Multiply in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes256_key_step.sv
// One AES-256 expansion step: derives the next four key words from the 8-word window.
// Parity of the target round index selects RotWord+Rcon (even) or plain SubWord (odd).
module aes256_key_step
  import aes_pkg::*;
(
  input  logic [AES_256_KEY_LENGTH-1:0] window_i,
  input  roundIdx_t                     roundIdx_i,
  output logic [AES_BLOCK_SIZE-1:0]     nextKey_o
);

  logic [31:0] lastWord;
  logic [31:0] sboxIn;
  logic [31:0] subWord;
  logic [31:0] temp;
  logic [31:0] n1, n2, n3, n4;
  logic        unused_hiWords;

  // Only word 8 of the hi half feeds the recurrence; words 5-7 pass through the window.
  assign unused_hiWords = ^window_i[255:160];
  assign lastWord       = window_i[159:128];
  assign sboxIn         = roundIdx_i[0] ? lastWord : {lastWord[23:0], lastWord[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sboxIn[8*g +: 8]),
      .out_o (subWord[8*g +: 8])
    );
  end

  assign temp = subWord ^ (roundIdx_i[0] ? 32'h0 : rcon(roundIdx_i[3:1]));
  assign n1   = window_i[127:96] ^ temp;
  assign n2   = window_i[95:64]  ^ n1;
  assign n3   = window_i[63:32]  ^ n2;
  assign n4   = window_i[31:0]   ^ n3;

  assign nextKey_o = {n1, n2, n3, n4};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse (x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  assign x2   = gfMul(in_i, in_i);
  assign x3   = gfMul(x2, in_i);
  assign x6   = gfMul(x3, x3);
  assign x12  = gfMul(x6, x6);
  assign x15  = gfMul(x12, x3);
  assign x30  = gfMul(x15, x15);
  assign x60  = gfMul(x30, x30);
  assign x120 = gfMul(x60, x60);
  assign x240 = gfMul(x120, x120);
  assign x252 = gfMul(x240, x12);
  assign inv  = gfMul(x252, x2);

  assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes256_key_schedule_ctrl.sv
// Iterative AES-256 key-schedule sequencer: accepts a 256-bit key and streams
// round keys 0..14 over a valid/ready handshake using one shared expansion step.
module aes256_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUND_KEYS = AES256_NUM_ROUND_KEYS
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Key_valid,
  output logic                          Key_ready,
  input  logic [AES_256_KEY_LENGTH-1:0] Input_key,
  output logic                          Round_key_valid,
  input  logic                          Round_key_ready,
  output logic [AES_BLOCK_SIZE-1:0]     Round_key,
  output roundIdx_t                     Round_key_index,
  output logic                          Busy,
  output logic                          Done
);

  if (NUM_ROUND_KEYS != AES256_NUM_ROUND_KEYS) begin : g_bad_round_key_count
    $error("NUM_ROUND_KEYS must be 15 for AES-256");
  end

  localparam roundIdx_t LAST_IDX = roundIdx_t'(NUM_ROUND_KEYS - 1);

  state_e                        state_q;
  logic [AES_256_KEY_LENGTH-1:0] window_q;
  roundIdx_t                     index_q;
  logic                          keyReady_q;
  logic                          rkValid_q;
  logic                          busy_q;
  logic                          done_q;
  logic [AES_BLOCK_SIZE-1:0]     stepKey_d;
  roundIdx_t                     stepIdx_d;

  // The step always targets the key two positions ahead of the one being emitted.
  assign stepIdx_d = index_q + roundIdx_t'(2);

  aes256_key_step u_step (
    .window_i   (window_q),
    .roundIdx_i (stepIdx_d),
    .nextKey_o  (stepKey_d)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      window_q   <= '0;
      index_q    <= '0;
      keyReady_q <= 1'b1;
      rkValid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Key_valid && keyReady_q) begin
            window_q   <= {Input_key[AES_BLOCK_SIZE-1:0], Input_key[AES_256_KEY_LENGTH-1:AES_BLOCK_SIZE]};
            index_q    <= '0;
            state_q    <= EMIT;
            keyReady_q <= 1'b0;
            rkValid_q  <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        EMIT: begin
          if (Round_key_ready) begin
            if (index_q == LAST_IDX) begin
              state_q    <= IDLE;
              keyReady_q <= 1'b1;
              rkValid_q  <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              // Slide the window: old hi becomes the next emitted key, new words enter hi.
              window_q <= {stepKey_d, window_q[AES_256_KEY_LENGTH-1:AES_BLOCK_SIZE]};
              index_q  <= index_q + roundIdx_t'(1);
            end
          end
        end
      endcase
    end
  end

  assign Key_ready       = keyReady_q;
  assign Round_key_valid = rkValid_q;
  assign Round_key       = window_q[AES_BLOCK_SIZE-1:0];
  assign Round_key_index = index_q;
  assign Busy            = busy_q;
  assign Done            = done_q;

  a_index_in_range: assert property (@(posedge Clk) disable iff (!Rst_n) index_q != 4'hF);

endmodule

// File: doc/aes256_key_schedule_ctrl.md
Name: aes256_key_schedule_ctrl

Overview:
Iterative AES-256 key-schedule sequencer. It accepts one 256-bit cipher key and streams the 15 round keys (indices 0..14, 128 bits each) to the round datapath, one per output handshake. Internally it time-multiplexes a single runtime-configurable expansion step, instead of instantiating 13 parameterised expansion stages. It sits between the key-load interface and the encrypt/decrypt round engine, or the engine's round-key store.

Parameters:
NUM_ROUND_KEYS, 15, number of round keys emitted per key load; fixed by AES-256 and checked by elaboration assertion.

Ports:
Clk  input  1  system clock, all state on rising edge
Rst_n  input  1  asynchronous active-low reset
Key_valid  input  1  Input_key is valid
Key_ready  output  1  controller can accept a new key
Input_key  input  `AES_256_KEY_LENGTH  cipher key, word/byte order per aes_defines
Round_key_valid  output  1  Round_key and Round_key_index are valid
Round_key_ready  input  1  consumer accepts the current round key
Round_key  output  `AES_BLOCK_SIZE  current round key
Round_key_index  output  4  index 0..14 of Round_key
Busy  output  1  high from key acceptance until last round key accepted
Done  output  1  one-cycle pulse in the cycle after round key 14 is accepted

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, Key_ready=1, Round_key_valid=0, Round_key=0, Round_key_index=0, Busy=0, Done=0, 256-bit window register=0.
- Window register W = {hi, lo}; Round_key is always W's lo half.
- FSM states: IDLE, EMIT.
- IDLE:
  - Key_ready=1.
  - On Key_valid&&Key_ready: W<=Input_key (lo = words 1-4, hi = words 5-8), index<=0, go to EMIT.
  - Round_key_valid rises on the next cycle (1-cycle latency).
- EMIT:
  - Key_ready=0; Key_valid is ignored and no key is captured.
  - Round_key_valid=1. Round_key and Round_key_index are held stable while Round_key_ready=0.
  - On handshake with index<14: W<={step(W, index+2), hi}, index<=index+1. The next key is valid in the following cycle, so throughput is 1 key/cycle with Round_key_ready held high.
  - On handshake with index==14: go to IDLE, Done=1 for one cycle, Busy=0 in the same cycle as Done, Key_ready=1 in that cycle.
- step(W,k) for k=2..14 produces {lo^f, ...} chained word-XOR exactly as the FIPS-197 w[i]=w[i-8]^temp recurrence:
  - k even: temp = SubWord(RotWord(hi word 8)) ^ Rcon[k/2], with Rcon[1..7] = 01,02,04,08,10,20,40 in the first byte.
  - k odd: temp = SubWord(hi word 8), no rotation, no Rcon.
  - Word 1 = lo.w1^temp; word n = lo.wn^new word n-1.
- Round keys 0 and 1 are emitted unmodified from Input_key; no step is evaluated for them.
- Reset mid-sequence: immediate return to IDLE, all outputs reset. No partial-key state survives.
- Key_valid asserted during EMIT: it stays pending upstream and is accepted in the IDLE cycle after Done.
- Round_key_ready high while Round_key_valid=0 has no effect.
- Index wrap: the index never exceeds 14; an index counter of 15 is unreachable (assertion).
- Exactly 4 S-box instances in the whole block, shared between odd and even steps.

Decomposition:
- Package aes_pkg, alongside the aes_defines macros:
  - AES-256 round-key count (15).
  - Rcon lookup function (index 1..7 to word).
  - Round-index typedef (logic [3:0]).
  - FSM state enum {IDLE, EMIT}.
- Sub-module aes256_key_step (combinational):
  - Inputs: 256-bit window, 4-bit round index.
  - Output: 128-bit next round key.
  - Runtime parity select for RotWord/Rcon; instantiates 4 aes_sbox.
- The controller holds the FSM, the window register and the handshakes.

Test Plan:
1. FIPS-197 C.3 key 000102..1f, Round_key_ready tied 1 -> indices 0..14 on consecutive cycles. Key0=00010203..0c0d0e0f, key1=10111213..1c1d1e1f, key2=a573c29fa176c498a97fce93a572c09c, key3=1651a8cd0244beda1a5da4c10640bade, key14=24fc79ccbf0979e9371ac23c6d68de36. Done pulses once; Busy is high for 15 cycles.
2. Same key with Round_key_ready toggled randomly (~50%) -> identical key sequence. Round_key/index stable whenever valid&&!ready; exactly 15 handshakes.
3. Key_valid held high continuously with two back-to-back keys (C.3 key, then all-ff key) -> second key accepted only in the Done cycle, with Key_ready high only then. The second sequence starts at index 0 and is correct against the software model.
4. Rst_n asserted at index 7 while valid&&!ready -> outputs go to reset values asynchronously. A new key after release restarts at index 0 with a correct sequence.
5. Random 1000 keys with random backpressure vs. the C reference model -> all 15000 round keys match; no handshake-protocol assertion fires.
